// File: rtl/iir_pkg.sv
// iir_pkg: shared constants, FSM states and fixed-point conversion helpers for the biquad stage
package iir_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 11;
  localparam int ACC_W = 20;
  localparam logic [DATA_W-2:0] SAT_MAX_MAG = 15'h7FFF;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, ROUND, OUT} state_t;
  function automatic logic signed [ACC_W-1:0] sm2tc(input logic [DATA_W-1:0] v);
    logic signed [ACC_W-1:0] m;
    m = signed'({{(ACC_W-DATA_W+1){1'b0}}, v[DATA_W-2:0]});
    return v[DATA_W-1] ? -m : m;
  endfunction
  function automatic logic [ACC_W-1:0] tc_mag(input logic signed [ACC_W-1:0] a);
    return a[ACC_W-1] ? -a : a;
  endfunction
  function automatic logic is_sat(input logic signed [ACC_W-1:0] a);
    return tc_mag(a) > ACC_W'(SAT_MAX_MAG);
  endfunction
  function automatic logic [DATA_W-1:0] tc2sm_sat(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-1:0] mag;
    mag = tc_mag(a);
    return {a[ACC_W-1], mag > ACC_W'(SAT_MAX_MAG) ? SAT_MAX_MAG : mag[DATA_W-2:0]};
  endfunction
endpackage

// File: rtl/iir_sat_acc.sv
// iir_sat_acc: two's complement product accumulator with saturating sign-magnitude output (sticky flag with IIR_SAT_STICKY_EN)
module iir_sat_acc
  import iir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] prod,
`ifdef IIR_SAT_STICKY_EN
  input  logic              rnd,
  output logic              sat_sticky,
`endif
  output logic [DATA_W-1:0] res
);
  logic signed [ACC_W-1:0] acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + sm2tc(prod);
  assign res = tc2sm_sat(acc);
`ifdef IIR_SAT_STICKY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_sticky <= 1'b0;
    else if (rnd && is_sat(acc)) sat_sticky <= 1'b1;
`endif
endmodule

// File: rtl/multiplier.sv
// multiplier: S.4.11 sign-magnitude product, magnitude truncated to 15 bits
module multiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  logic [29:0] m;
  assign m = a[14:0] * b[14:0];
  assign p = {a[15] ^ b[15], 15'(m >> 11)};
endmodule

// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq: sequential DF-I biquad on one shared multiplier; IIR_SAT_STICKY_EN adds the sat_sticky port
module iir_biquad_seq
  import iir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic [DATA_W-1:0] coef_b0,
  input  logic [DATA_W-1:0] coef_b1,
  input  logic [DATA_W-1:0] coef_b2,
  input  logic [DATA_W-1:0] coef_a1,
  input  logic [DATA_W-1:0] coef_a2,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef IIR_SAT_STICKY_EN
  output logic              sat_sticky,
`endif
  output logic [DATA_W-1:0] out_sample
);
  state_t state;
  logic [2:0] k;
  logic [DATA_W-1:0] x0, x1, x2, y1, y2, coef_sel, data_sel, prod, prod_q, res;
  logic prod_v;
  always_comb begin
    coef_sel = k == 3'd0 ? coef_b0 :
               k == 3'd1 ? coef_b1 :
               k == 3'd2 ? coef_b2 :
               k == 3'd3 ? {~coef_a1[DATA_W-1], coef_a1[DATA_W-2:0]} :
                           {~coef_a2[DATA_W-1], coef_a2[DATA_W-2:0]};
    data_sel = k == 3'd0 ? x0 : k == 3'd1 ? x1 : k == 3'd2 ? x2 : k == 3'd3 ? y1 : y2;
  end
  multiplier u_mul (.a(coef_sel), .b(data_sel), .p(prod));
  iir_sat_acc u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE && in_valid),
    .en(prod_v),
    .prod(prod_q),
`ifdef IIR_SAT_STICKY_EN
    .rnd(state == ROUND),
    .sat_sticky(sat_sticky),
`endif
    .res(res)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_sample <= '0;
      prod_q <= '0;
      prod_v <= 1'b0;
      {x0, x1, x2, y1, y2} <= '0;
    end else begin
      prod_q <= prod;
      prod_v <= state == MAC;
      case (state)
        IDLE: if (in_valid) begin
          x0 <= in_sample;
          k <= '0;
          in_ready <= 1'b0;
          state <= MAC;
        end
        MAC: begin
          k <= k + 3'd1;
          if (k == 3'd4) state <= DRAIN;
        end
        DRAIN: state <= ROUND;
        ROUND: begin
          out_sample <= res;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          x2 <= x1;
          x1 <= x0;
          y2 <= y1;
          y1 <= out_sample;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb_iir_biquad_seq: randomized scoreboard bench against an arithmetic biquad reference model
module tb_iir_biquad_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] in_sample = 0, b0 = 0, b1 = 0, b2 = 0, a1 = 0, a2 = 0, out_sample;
`ifdef IIR_SAT_STICKY_EN
  logic sat_sticky;
`endif
  int n_cmp = 0, n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

  iir_biquad_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .coef_b0(b0), .coef_b1(b1), .coef_b2(b2), .coef_a1(a1), .coef_a2(a2),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef IIR_SAT_STICKY_EN
    .sat_sticky(sat_sticky),
`endif
    .out_sample(out_sample)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mul(input logic [15:0] c, input logic [15:0] d);
    int cm, dm, m;
    cm = int'(c[14:0]);
    dm = int'(d[14:0]);
    m = ((cm * dm) >>> 11) & 32'h7FFF;
    return (c[15] ^ d[15]) ? -m : m;
  endfunction

  function automatic logic [15:0] model_y(input logic [15:0] x);
    int s;
    s = mul(b0, x) + mul(b1, mx1) + mul(b2, mx2) - mul(a1, my1) - mul(a2, my2);
    if (s > 32767) s = 32767;
    if (s < -32767) s = -32767;
    return s < 0 ? {1'b1, 15'(-s)} : {1'b0, 15'(s)};
  endfunction

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected none", out_sample);
      end else chk("out_sample", {16'h0, out_sample}, {16'h0, exp_q.pop_front()});
    end

  task automatic model_reset();
    exp_q.delete();
    {mx1, mx2, my1, my2} = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic send(input logic [15:0] x, input int hold, input int lit);
    int c;
    logic [15:0] ym, e;
    c = 0;
    while (!in_ready && c < 50) begin
      @(posedge clk);
      #1 c++;
    end
    chk("in_ready_wait", {31'h0, in_ready}, 1);
    in_sample = x;
    in_valid = 1;
    ym = model_y(x);
    e = lit >= 0 ? 16'(lit) : ym;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 0;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk);
      #1 c++;
    end
    chk("latency", c, 7);
    for (int i = 0; i < hold; i++) begin
      chk("hold_sample", {16'h0, out_sample}, {16'h0, e});
      chk("hold_in_ready", {31'h0, in_ready}, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("post_in_ready", {31'h0, in_ready}, 1);
    chk("post_out_valid", {31'h0, out_valid}, 0);
    mx2 = mx1;
    mx1 = x;
    my2 = my1;
    my1 = ym;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_sample", {16'h0, out_sample}, 0);
`ifdef IIR_SAT_STICKY_EN
    chk("rst_sticky", {31'h0, sat_sticky}, 0);
`endif
    rst_n = 1;
    @(posedge clk);
    #1;
    b0 = 16'h0800;
    send(16'h1E00, 0, 'h1E00);
    b0 = 16'h8800;
    send(16'h1E00, 0, 'h9E00);
    do_reset();
    b0 = 16'h0800;
    a1 = 16'h8400;
    send(16'h0800, 0, 'h0800);
    send(16'h0000, 0, 'h0400);
    send(16'h0000, 0, 'h0200);
    do_reset();
    a1 = 0;
    b0 = 16'h2000;
    b1 = 16'h2000;
    b2 = 16'h2000;
    send(16'h1800, 0, 'h6000);
`ifdef IIR_SAT_STICKY_EN
    chk("sticky_clear", {31'h0, sat_sticky}, 0);
`endif
    send(16'h1800, 0, 'h7FFF);
`ifdef IIR_SAT_STICKY_EN
    chk("sticky_set", {31'h0, sat_sticky}, 1);
`endif
    b0 = 16'h0800;
    b1 = 0;
    b2 = 0;
    send(16'h1E00, 10, 'h1E00);
    in_sample = 16'h1E00;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_out_valid", {31'h0, out_valid}, 0);
    chk("abort_in_ready", {31'h0, in_ready}, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (8) @(posedge clk);
    #1 chk("abort_no_output", {31'h0, out_valid}, 0);
    send(16'h1E00, 0, 'h1E00);
    do_reset();
    repeat (40) begin
      b0 = {1'($urandom), 15'($urandom_range(0, 'h0FFF))};
      b1 = {1'($urandom), 15'($urandom_range(0, 'h0FFF))};
      b2 = {1'($urandom), 15'($urandom_range(0, 'h0FFF))};
      a1 = {1'($urandom), 15'($urandom_range(0, 'h0FFF))};
      a2 = {1'($urandom), 15'($urandom_range(0, 'h07FF))};
      send(16'($urandom), int'($urandom_range(0, 3)), -1);
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
